// File: rtl/mem_access_stage_pkg.sv
// Shared types, default widths and helpers for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int DATA_W_DEF  = 20;
    localparam int ADDR_W_DEF  = 20;
    localparam int INSTR_W_DEF = 20;
    localparam int TIMEOUT_DEF = 15;
    localparam int MAX_W       = 64;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        HOLD,
        DRAIN
    } stageState_t;

    // Zero-extends or truncates an address to the result width; callers cast down from MAX_W.
    function automatic logic [MAX_W-1:0] resizeAddr(input logic [MAX_W-1:0] addr, input int dataW);
        logic [MAX_W-1:0] r;
        r = addr;
        for (int i = 0; i < MAX_W; i++) begin
            if (i >= dataW) r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundle of the EX-side, memory-side and WB-side handshakes of the memory-access stage.
// master is the stage's own view; slave is the surrounding pipeline and memory.
interface mem_access_stage_if
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               flush;
    logic               inValid;
    logic               inReady;
    logic [INSTR_W-1:0] inInstruction;
    logic [ADDR_W-1:0]  inAddress;
    logic [DATA_W-1:0]  inWriteData;
    logic               inWriteEnable;
    logic               inReadEnable;
    logic               memReq;
    logic               memWe;
    logic [ADDR_W-1:0]  memAddr;
    logic [DATA_W-1:0]  memWdata;
    logic               memAck;
    logic [DATA_W-1:0]  memRdata;
    logic               outValid;
    logic               outReady;
    logic [INSTR_W-1:0] outInstruction;
    logic [DATA_W-1:0]  outResult;
    logic               outIsLoad;
    logic               outError;
    logic               busy;

    modport master (
        input  flush, inValid, inInstruction, inAddress, inWriteData, inWriteEnable,
               inReadEnable, memAck, memRdata, outReady,
        output inReady, memReq, memWe, memAddr, memWdata, outValid, outInstruction,
               outResult, outIsLoad, outError, busy
    );

    modport slave (
        output flush, inValid, inInstruction, inAddress, inWriteData, inWriteEnable,
               inReadEnable, memAck, memRdata, outReady,
        input  inReady, memReq, memWe, memAddr, memWdata, outValid, outInstruction,
               outResult, outIsLoad, outError, busy
    );

endinterface

// File: rtl/mem_access_stage_timer.sv
// Counts cycles a memory request has waited; expired_o flags the last permitted cycle.
module mem_req_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted on the TIMEOUT-th waiting cycle so memReq is high for exactly TIMEOUT cycles.
    assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// Registered, handshaked memory-access stage between execute and write-back.
// Single entry: capture from EX, complete the memory access, hold the result for WB.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clock,
    input  logic               resetn,
    mem_access_stage_if.master bus
);
    stageState_t        state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               isStore_q, isStore_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               isLoad_q, isLoad_d;
    logic               error_q, error_d;

    logic inReady, accept, memActive, timerClear, timerExpired;

    function automatic logic [DATA_W-1:0] toResult(input logic [ADDR_W-1:0] a);
        return DATA_W'(resizeAddr(MAX_W'(a), DATA_W));
    endfunction

    assign memActive = (state_q == MEM) || (state_q == DRAIN);
    assign inReady   = resetn && !bus.flush &&
                       ((state_q == IDLE) || ((state_q == HOLD) && bus.outReady));
    assign accept    = bus.inValid && inReady;

    // A fresh timeout window starts whenever MEM or DRAIN is entered.
    assign timerClear = ((state_d == MEM) && (state_q != MEM)) ||
                        ((state_d == DRAIN) && (state_q != DRAIN));

    mem_req_timer #(.TIMEOUT(TIMEOUT)) timer (
        .clock     (clock),
        .resetn    (resetn),
        .clear_i   (timerClear),
        .enable_i  (memActive && !bus.memAck),
        .expired_o (timerExpired)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        isStore_d = isStore_q;
        result_d  = result_q;
        isLoad_d  = isLoad_q;
        error_d   = error_q;
        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    instr_d   = bus.inInstruction;
                    addr_d    = bus.inAddress;
                    wdata_d   = bus.inWriteData;
                    isStore_d = bus.inWriteEnable;
                    result_d  = toResult(bus.inAddress);
                    isLoad_d  = 1'b0;
                    error_d   = 1'b0;
                    state_d   = (bus.inWriteEnable || bus.inReadEnable) ? MEM : HOLD;
                end else if (bus.flush || ((state_q == HOLD) && bus.outReady)) begin
                    state_d = IDLE;
                end
            end
            MEM: begin
                // An ack coinciding with a flush still completes the bus cycle, so no drain is needed.
                if (bus.memAck) begin
                    state_d = bus.flush ? IDLE : HOLD;
                    if (isStore_q) begin
                        result_d = toResult(addr_q);
                    end else begin
                        result_d = bus.memRdata;
                        isLoad_d = 1'b1;
                    end
                end else if (timerExpired) begin
                    state_d  = bus.flush ? IDLE : HOLD;
                    result_d = '0;
                    error_d  = 1'b1;
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.memAck || timerExpired) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            isStore_q <= 1'b0;
            result_q  <= '0;
            isLoad_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            isStore_q <= isStore_d;
            result_q  <= result_d;
            isLoad_q  <= isLoad_d;
            error_q   <= error_d;
        end
    end

    assign bus.inReady        = inReady;
    assign bus.memReq         = memActive;
    assign bus.memWe          = memActive && isStore_q;
    assign bus.memAddr        = addr_q;
    assign bus.memWdata       = wdata_q;
    assign bus.outValid       = (state_q == HOLD);
    assign bus.outInstruction = instr_q;
    assign bus.outResult      = result_q;
    assign bus.outIsLoad      = isLoad_q;
    assign bus.outError       = error_q;
    assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT = 4 and hand-computed expectations.
module tb_mem_access_stage;

    logic clock;
    logic resetn;
    int   checkCount;
    int   errorCount;

    mem_access_stage_if #(.DATA_W(20), .ADDR_W(20), .INSTR_W(20)) bus ();

    mem_access_stage #(
        .DATA_W (20),
        .ADDR_W (20),
        .INSTR_W(20),
        .TIMEOUT(4)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [19:0] instr, input logic [19:0] addr,
                                 input logic [19:0] wdata, input logic we, input logic re);
        bus.inValid       = valid;
        bus.inInstruction = instr;
        bus.inAddress     = addr;
        bus.inWriteData   = wdata;
        bus.inWriteEnable = we;
        bus.inReadEnable  = re;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        resetn       = 1'b0;
        bus.flush    = 1'b0;
        bus.memAck   = 1'b0;
        bus.memRdata = '0;
        bus.outReady = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);

        tick();
        tick();
        checkOutput("rst inReady", 32'(bus.inReady), 32'd0);
        checkOutput("rst outValid", 32'(bus.outValid), 32'd0);
        checkOutput("rst memReq", 32'(bus.memReq), 32'd0);
        checkOutput("rst busy", 32'(bus.busy), 32'd0);
        checkOutput("rst outResult", 32'(bus.outResult), 32'd0);
        resetn = 1'b1;
        #1;
        checkOutput("rel inReady", 32'(bus.inReady), 32'd1);

        // ALU pass-through, four back-to-back ops with WB always ready
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 20'h11110 + 20'(i), 20'h0ABCD + 20'(i), '0, 1'b0, 1'b0);
            #1;
            checkOutput("alu inReady", 32'(bus.inReady), 32'd1);
            if (i > 0) begin
                checkOutput("alu outValid", 32'(bus.outValid), 32'd1);
                checkOutput("alu outInstr", 32'(bus.outInstruction), 32'h11110 + 32'(i - 1));
                checkOutput("alu outResult", 32'(bus.outResult), 32'h0ABCD + 32'(i - 1));
                checkOutput("alu outIsLoad", 32'(bus.outIsLoad), 32'd0);
            end
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("alu last valid", 32'(bus.outValid), 32'd1);
        checkOutput("alu last result", 32'(bus.outResult), 32'h0ABD0);
        tick();
        checkOutput("alu drained", 32'(bus.outValid), 32'd0);

        // Load, memory acks on the third request cycle, WB stalls two cycles
        applyStimulus(1'b1, 20'h22222, 20'h00010, '0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                bus.memAck   = 1'b1;
                bus.memRdata = 20'h12345;
                bus.outReady = 1'b0;
            end
            #1;
            checkOutput("ld memReq", 32'(bus.memReq), 32'd1);
            checkOutput("ld memWe", 32'(bus.memWe), 32'd0);
            checkOutput("ld memAddr", 32'(bus.memAddr), 32'h00010);
            checkOutput("ld outValid", 32'(bus.outValid), 32'd0);
            checkOutput("ld inReady", 32'(bus.inReady), 32'd0);
            tick();
        end
        bus.memAck   = 1'b0;
        bus.memRdata = '0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus.outReady = 1'b1;
            #1;
            checkOutput("ld memReq off", 32'(bus.memReq), 32'd0);
            checkOutput("ld hold valid", 32'(bus.outValid), 32'd1);
            checkOutput("ld hold result", 32'(bus.outResult), 32'h12345);
            checkOutput("ld hold isLoad", 32'(bus.outIsLoad), 32'd1);
            checkOutput("ld hold instr", 32'(bus.outInstruction), 32'h22222);
            checkOutput("ld hold error", 32'(bus.outError), 32'd0);
            tick();
        end
        checkOutput("ld released", 32'(bus.outValid), 32'd0);

        // Zero-wait store
        applyStimulus(1'b1, 20'h33333, 20'h00020, 20'h0FFFF, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        bus.memAck = 1'b1;
        #1;
        checkOutput("st memReq", 32'(bus.memReq), 32'd1);
        checkOutput("st memWe", 32'(bus.memWe), 32'd1);
        checkOutput("st memWdata", 32'(bus.memWdata), 32'h0FFFF);
        checkOutput("st memAddr", 32'(bus.memAddr), 32'h00020);
        checkOutput("st early valid", 32'(bus.outValid), 32'd0);
        tick();
        bus.memAck = 1'b0;
        checkOutput("st memWe off", 32'(bus.memWe), 32'd0);
        checkOutput("st outValid", 32'(bus.outValid), 32'd1);
        checkOutput("st outResult", 32'(bus.outResult), 32'h00020);
        checkOutput("st outIsLoad", 32'(bus.outIsLoad), 32'd0);
        tick();

        // Timeout: no ack ever, request must last exactly four cycles
        applyStimulus(1'b1, 20'h44444, 20'h00040, '0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("to memReq", 32'(bus.memReq), 32'd1);
            tick();
        end
        checkOutput("to memReq off", 32'(bus.memReq), 32'd0);
        checkOutput("to outValid", 32'(bus.outValid), 32'd1);
        checkOutput("to outError", 32'(bus.outError), 32'd1);
        checkOutput("to outResult", 32'(bus.outResult), 32'd0);
        tick();

        // Ack on the last allowed cycle wins; both enables high means store
        applyStimulus(1'b1, 20'h55555, 20'h00050, 20'h01234, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.memAck = 1'b1;
            checkOutput("lim memReq", 32'(bus.memReq), 32'd1);
            checkOutput("lim memWe", 32'(bus.memWe), 32'd1);
            tick();
        end
        bus.memAck = 1'b0;
        checkOutput("lim outValid", 32'(bus.outValid), 32'd1);
        checkOutput("lim outError", 32'(bus.outError), 32'd0);
        checkOutput("lim outResult", 32'(bus.outResult), 32'h00050);
        tick();

        // Flush during MEM: request drains, no result is produced
        applyStimulus(1'b1, 20'h66666, 20'h00060, '0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        #1;
        checkOutput("fl inReady", 32'(bus.inReady), 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        checkOutput("fl drain req", 32'(bus.memReq), 32'd1);
        checkOutput("fl drain valid", 32'(bus.outValid), 32'd0);
        checkOutput("fl drain ready", 32'(bus.inReady), 32'd0);
        tick();
        bus.memAck   = 1'b1;
        bus.memRdata = 20'h77777;
        checkOutput("fl ack req", 32'(bus.memReq), 32'd1);
        tick();
        bus.memAck   = 1'b0;
        bus.memRdata = '0;
        checkOutput("fl done req", 32'(bus.memReq), 32'd0);
        checkOutput("fl done valid", 32'(bus.outValid), 32'd0);
        checkOutput("fl done ready", 32'(bus.inReady), 32'd1);
        checkOutput("fl done busy", 32'(bus.busy), 32'd0);

        // Flush while holding a result withdraws it
        applyStimulus(1'b1, 20'h68686, 20'h00068, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        bus.outReady = 1'b0;
        bus.flush    = 1'b1;
        #1;
        checkOutput("flh valid", 32'(bus.outValid), 32'd1);
        tick();
        bus.flush    = 1'b0;
        bus.outReady = 1'b1;
        checkOutput("flh dropped", 32'(bus.outValid), 32'd0);

        // Reset in the middle of a request
        applyStimulus(1'b1, 20'h70707, 20'h00070, '0, 1'b0, 1'b1);
        tick();
        checkOutput("rm memReq", 32'(bus.memReq), 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("rm inReady", 32'(bus.inReady), 32'd0);
        tick();
        checkOutput("rm memReq off", 32'(bus.memReq), 32'd0);
        checkOutput("rm memAddr", 32'(bus.memAddr), 32'd0);
        checkOutput("rm outInstr", 32'(bus.outInstruction), 32'd0);
        checkOutput("rm busy", 32'(bus.busy), 32'd0);
        tick();
        tick();
        checkOutput("rm held req", 32'(bus.memReq), 32'd0);
        checkOutput("rm held ready", 32'(bus.inReady), 32'd0);
        resetn = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("rm release ready", 32'(bus.inReady), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Registered, handshaked memory-access stage for the 20-bit pipeline processor, successor to the combinational pass-through MEM stage. Sits between execute and write-back. Accepts one instruction at a time from EX, issues a load/store to a variable-latency data memory over a req/ack port, and presents the result to WB under valid/ready back-pressure. Adds flush, memory timeout with error reporting, and parametrised widths.

## Interface
- DATA_W, 20, data/result width
- ADDR_W, 20, memory address width
- INSTR_W, 20, instruction word width
- TIMEOUT, 15, max cycles waiting for memAck (≥1)

- clock  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- flush  in  1  discard in-flight instruction (synchronous)
- inValid  in  1  EX presents an instruction
- inReady  out  1  stage can accept this cycle
- inInstruction  in  INSTR_W  instruction word, propagated
- inAddress  in  ADDR_W  memory address / ALU result
- inWriteData  in  DATA_W  store data
- inWriteEnable  in  1  store
- inReadEnable  in  1  load
- memReq  out  1  memory request, held until ack
- memWe  out  1  request is a write
- memAddr  out  ADDR_W  request address
- memWdata  out  DATA_W  store data
- memAck  in  1  memory completes request this cycle
- memRdata  in  DATA_W  load data, valid with memAck
- outValid  out  1  result available to WB
- outReady  in  1  WB accepts result
- outInstruction  out  INSTR_W  propagated instruction
- outResult  out  DATA_W  load data, else inAddress resized to DATA_W (zero-extend/truncate)
- outIsLoad  out  1  result came from memory
- outError  out  1  memory timed out; outResult = 0
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, MEM, HOLD, DRAIN. Single-entry stage.
- inReady = resetn && (IDLE || (HOLD && outReady)) && !flush. Accept = inValid && inReady.
- Accept of non-memory op (both enables low): capture, go HOLD, outResult = resized address.
- Accept of memory op: capture, go MEM. inWriteEnable has priority if both enables are high (treated as store).
- MEM: memReq = 1, memWe/memAddr/memWdata stable from captured entry. memAck is only meaningful while memReq = 1. On memAck: load → outResult = memRdata, outIsLoad = 1; store → outResult = resized address. Go HOLD.
- Timeout: counter clears on entry to MEM/DRAIN and increments each MEM/DRAIN cycle without ack. When it reaches TIMEOUT: drop memReq, go HOLD with outError = 1, outResult = 0. Go IDLE if in DRAIN. Ack in the same cycle as the limit wins (normal completion).
- HOLD: outValid = 1, outputs stable until outValid && outReady. Then go IDLE, or capture a new accept the same cycle.
- flush: IDLE/HOLD → IDLE, outValid drops next cycle. MEM → DRAIN, because a bus request cannot be aborted. DRAIN keeps memReq until ack or timeout, then IDLE with no output. flush in DRAIN has no further effect.
- resetn low overrides everything, including mid-request: memReq drops next edge with no drain.

## Timing
- Reset values: memReq, memWe, outValid, outIsLoad, outError, busy = 0. memAddr, memWdata, outInstruction, outResult = 0. inReady = 0 while resetn low. State IDLE, counter 0.
- Non-memory op accepted at edge N → outValid high from cycle N+1.
- Memory op accepted at N → memReq high from N+1. Ack sampled at edge M → outValid from M+1. Zero-wait memory (ack at N+1) gives 2-cycle latency.
- Timeout: memReq high for exactly TIMEOUT cycles, outError output the next cycle.
- Back-to-back non-memory ops with outReady = 1: one per cycle.

## Structure
- Package mem_stage_pkg: state enum (IDLE, MEM, HOLD, DRAIN), default width constants (20), TIMEOUT default, resize function address→DATA_W.
- Sub-module mem_req_timer: parametrised TIMEOUT counter with clear/enable inputs and an expired output, width $clog2(TIMEOUT+1).
- Top-level holds the FSM, the capture register and the output register.

## Test plan
- Reset: hold resetn low 3 cycles mid-MEM → all outputs 0, memReq low next edge, inReady = 0. Release → inReady = 1.
- ALU pass-through: inAddress = 20'h0ABCD, no enables, outReady = 1, 4 back-to-back → outResult 20'h0ABCD one cycle later, one result per cycle, outIsLoad = 0.
- Load with 3-cycle memory: addr 20'h00010, memRdata = 20'h12345 with ack on 3rd req cycle → memReq high 3 cycles, outResult = 20'h12345, outIsLoad = 1. outReady low 2 cycles → outputs held.
- Store zero-wait: addr 20'h00020, data 20'h0FFFF → memWe = 1, memWdata = 20'h0FFFF for 1 cycle, outResult = 20'h00020, outValid at N+2.
- Timeout: TIMEOUT = 4, memAck never → memReq high exactly 4 cycles, then outValid with outError = 1, outResult = 0. Repeat with ack on the 4th cycle → normal result, outError = 0.
- Flush in MEM: flush one cycle after load accept, ack 2 cycles later → memReq held until ack, no outValid, inReady returns the cycle after ack.
